serial_comparator: RTL



---
 rtl/cmp_pkg.sv | 20 ++
 rtl/cmp_chunk.sv | 26 ++
 rtl/serial_comparator.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared encodings for the serial comparator: result codes and FSM states.
package cmp_pkg;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [1:0] cmp_encode(input logic gt, input logic lt);
    if (gt)      return CMP_GT;
    else if (lt) return CMP_LT;
    else         return CMP_EQ;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice; flip_msb inverts both MSBs
// so that the top slice of a two's-complement operand orders correctly.
module cmp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             flip_msb,
  output logic             gt,
  output logic             lt
);

  logic [CHUNK-1:0] a_m;
  logic [CHUNK-1:0] b_m;

  always_comb begin
    a_m = a;
    b_m = b;
    a_m[CHUNK-1] = a[CHUNK-1] ^ flip_msb;
    b_m[CHUNK-1] = b[CHUNK-1] ^ flip_msb;
  end

  assign gt = (a_m > b_m);
  assign lt = (a_m < b_m);

endmodule

// File: rtl/serial_comparator.sv
// MSB-first multi-cycle signed/unsigned comparator, CHUNK bits per cycle, start/busy/done handshake.
// SERIAL_CMP_EARLY_EXIT_EN: stop on first differing chunk; otherwise fixed NCHUNK-cycle scan.
module serial_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             smode_q;
  logic [1:0]       result_q;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
  logic             decided;
`endif

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             flip;
  logic             gt;
  logic             lt;
  logic             diff;
  logic             last;

  // Chunk-select mux over the latched operands
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDXW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  assign flip = smode_q && (idx == IDX_TOP);
  assign diff = gt | lt;
  assign last = (idx == '0);

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (a_chunk),
    .b        (b_chunk),
    .flip_msb (flip),
    .gt       (gt),
    .lt       (lt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_BUSY;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      ST_BUSY: if (diff || last) state_nxt = ST_DONE;
`else
      ST_BUSY: if (last) state_nxt = ST_DONE;
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= IDX_TOP;
      a_q      <= '0;
      b_q      <= '0;
      smode_q  <= 1'b0;
      result_q <= CMP_EQ;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
      decided  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q     <= in1;
            b_q     <= in2;
            smode_q <= signed_mode;
            idx     <= IDX_TOP;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            decided <= 1'b0;
`endif
          end
        end
        ST_BUSY: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
          if (diff)      result_q <= cmp_encode(gt, lt);
          else if (last) result_q <= CMP_EQ;
          else           idx      <= idx - IDXW'(1);
`else
          // Sticky decision: only the first differing chunk may write the result
          if (!decided && diff) begin
            result_q <= cmp_encode(gt, lt);
            decided  <= 1'b1;
          end
          if (last) begin
            if (!decided && !diff) result_q <= CMP_EQ;
          end else begin
            idx <= idx - IDXW'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);
  assign result = result_q;

endmodule
